multicycle_controller: RTL and testbench

//  Main FSM + ALU/branch decoder sequencing the multicycle RV32I datapath (PC, IR, regfile, ALU, shared memory).

---
 rtl/multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main sequencing FSM and ALU/branch/immediate decoder for the multicycle RV32I datapath.
// Optional LUI/AUIPC support is enabled by defining U_TYPE_EN.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
`ifdef U_TYPE_EN
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
`else
        S_JALR2    = 4'd12
`endif
    } state_t;

    state_t      state_r;
    logic        legal_s;
    logic [2:0]  alu_dec_s;
    logic        taken_s;
    logic        pcwrite_s;
    logic        adrsrc_s;
    logic        memwrite_s;
    logic        irwrite_s;
    logic        regwrite_s;
    logic [1:0]  resultsrc_s;
    logic [1:0]  alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [2:0]  alucontrol_s;
    logic [2:0]  immsrc_s;
    logic        illegal_s;

    // Encoding legality check, evaluated while the fresh IR is visible in DECODE
    always_comb begin
        legal_s = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: legal_s = (funct3 == 3'b010);
            OP_R, OP_I:        legal_s = !((funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101));
            OP_BR:             legal_s = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                         (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_JAL:            legal_s = 1'b1;
            OP_JALR:           legal_s = (funct3 == 3'b000);
`ifdef U_TYPE_EN
            OP_LUI, OP_AUIPC:  legal_s = 1'b1;
`endif
            default:           legal_s = 1'b0;
        endcase
    end

    // ALU operation for register/immediate arithmetic and branch condition
    always_comb begin
        alu_dec_s = 3'b000;
        case (funct3)
            3'b000:  alu_dec_s = ((op == OP_R) && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_dec_s = 3'b101;
            3'b100:  alu_dec_s = 3'b100;
            3'b110:  alu_dec_s = 3'b011;
            3'b111:  alu_dec_s = 3'b010;
            default: alu_dec_s = 3'b000;
        endcase
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = zero;
            3'b001:  taken_s = ~zero;
            3'b100:  taken_s = lt;
            3'b101:  taken_s = ~lt;
            default: taken_s = 1'b0;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        immsrc_s = 3'b000;
        case (op)
            OP_LOAD, OP_I, OP_JALR: immsrc_s = 3'b000;
            OP_STORE:               immsrc_s = 3'b001;
            OP_BR:                  immsrc_s = 3'b010;
            OP_JAL:                 immsrc_s = 3'b100;
`ifdef U_TYPE_EN
            OP_LUI, OP_AUIPC:       immsrc_s = 3'b011;
`endif
            default:                immsrc_s = 3'b000;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    if (!legal_s) begin
                        state_r <= S_FETCH;
                    end else begin
                        case (op)
                            OP_LOAD, OP_STORE: state_r <= S_MEMADR;
                            OP_R:              state_r <= S_EXECR;
                            OP_I:              state_r <= S_EXECI;
                            OP_BR:             state_r <= S_BRANCH;
                            OP_JAL:            state_r <= S_JAL;
                            OP_JALR:           state_r <= S_JALR1;
`ifdef U_TYPE_EN
                            OP_LUI:            state_r <= S_LUI;
                            OP_AUIPC:          state_r <= S_AUIPC;
`endif
                            default:           state_r <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:   state_r <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_r <= S_MEMWB;
                S_MEMWB:    state_r <= S_FETCH;
                S_MEMWRITE: state_r <= S_FETCH;
                S_EXECR:    state_r <= S_ALUWB;
                S_EXECI:    state_r <= S_ALUWB;
                S_ALUWB:    state_r <= S_FETCH;
                S_BRANCH:   state_r <= S_FETCH;
                S_JAL:      state_r <= S_ALUWB;
                S_JALR1:    state_r <= S_JALR2;
                S_JALR2:    state_r <= S_ALUWB;
`ifdef U_TYPE_EN
                S_LUI:      state_r <= S_ALUWB;
                S_AUIPC:    state_r <= S_ALUWB;
`endif
                default:    state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls
    always_comb begin
        pcwrite_s    = 1'b0;
        adrsrc_s     = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        resultsrc_s  = 2'b00;
        alusrca_s    = 2'b00;
        alusrcb_s    = 2'b00;
        alucontrol_s = 3'b000;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                irwrite_s   = 1'b1;
                pcwrite_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                illegal_s = ~legal_s;
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            S_MEMREAD:  adrsrc_s = 1'b1;
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECR: begin
                alusrca_s    = 2'b10;
                alucontrol_s = alu_dec_s;
            end
            S_EXECI: begin
                alusrca_s    = 2'b10;
                alusrcb_s    = 2'b01;
                alucontrol_s = alu_dec_s;
            end
            S_ALUWB:    regwrite_s = 1'b1;
            S_BRANCH: begin
                alusrca_s    = 2'b10;
                alucontrol_s = 3'b001;
                pcwrite_s    = taken_s;
            end
            S_JAL, S_JALR2: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_JALR1: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
`ifdef U_TYPE_EN
            S_LUI: begin
                alusrca_s = 2'b11;
                alusrcb_s = 2'b01;
            end
            S_AUIPC: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
            end
`endif
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    // Enables are suppressed for as long as reset is held
    assign PCWrite    = pcwrite_s  & ~rst;
    assign IRWrite    = irwrite_s  & ~rst;
    assign RegWrite   = regwrite_s & ~rst;
    assign MemWrite   = memwrite_s & ~rst;
    assign illegal    = illegal_s  & ~rst;
    assign AdrSrc     = adrsrc_s;
    assign ResultSrc  = resultsrc_s;
    assign ALUSrcA    = alusrca_s;
    assign ALUSrcB    = alusrcb_s;
    assign ALUControl = alucontrol_s;
    assign ImmSrc     = immsrc_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases plus random instructions checked
// against a per-instruction-class cycle table built from the ISA sequencing rules.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int tests = 0;
    int fails = 0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5,
                   C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [6:0] o, input logic [2:0] f);
        case (o)
            7'b0000011: return (f == 3'd2) ? C_LW : C_ILL;
            7'b0100011: return (f == 3'd2) ? C_SW : C_ILL;
            7'b0110011: return (f == 3'd1 || f == 3'd3 || f == 3'd5) ? C_ILL : C_R;
            7'b0010011: return (f == 3'd1 || f == 3'd3 || f == 3'd5) ? C_ILL : C_I;
            7'b1100011: return (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) ? C_BR : C_ILL;
            7'b1101111: return C_JAL;
            7'b1100111: return (f == 3'd0) ? C_JALR : C_ILL;
`ifdef U_TYPE_EN
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
`endif
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int latency(input int cls);
        int lat_tab [10] = '{5, 4, 4, 4, 3, 4, 5, 4, 4, 2};
        return lat_tab[cls];
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b100;
`ifdef U_TYPE_EN
            7'b0110111, 7'b0010111: return 3'b011;
`endif
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f, input logic f7);
        case (f)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction, packed as
    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
    function automatic logic [17:0] model(input int cls, input int k, input logic [6:0] o,
                                          input logic [2:0] f, input logic f7,
                                          input logic z, input logic l);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, ill = 1'b0;
        logic [1:0] rs = 2'b00, a = 2'b00, b = 2'b00;
        logic [2:0] alu = 3'b000;
        if (k == 0) begin
            pcw = 1'b1; irw = 1'b1; rs = 2'b10; b = 2'b10;
        end else if (k == 1) begin
            a = 2'b01; b = 2'b01; ill = (cls == C_ILL);
        end else begin
            case (cls)
                C_LW: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; end
                    if (k == 3) adr = 1'b1;
                    if (k == 4) begin rs = 2'b01; rw = 1'b1; end
                end
                C_SW: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; end
                    if (k == 3) begin adr = 1'b1; mw = 1'b1; end
                end
                C_R, C_I: begin
                    if (k == 2) begin
                        a = 2'b10; b = (cls == C_R) ? 2'b00 : 2'b01; alu = alu_of(o, f, f7);
                    end
                    if (k == 3) rw = 1'b1;
                end
                C_BR: begin
                    a = 2'b10; alu = 3'b001;
                    pcw = (f == 3'd0) ? z : (f == 3'd1) ? ~z : (f == 3'd4) ? l : ~l;
                end
                C_JAL: begin
                    if (k == 2) begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
                    if (k == 3) rw = 1'b1;
                end
                C_JALR: begin
                    if (k == 2) begin a = 2'b10; b = 2'b01; end
                    if (k == 3) begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
                    if (k == 4) rw = 1'b1;
                end
                C_LUI, C_AUIPC: begin
                    if (k == 2) begin a = (cls == C_LUI) ? 2'b11 : 2'b01; b = 2'b01; end
                    if (k == 3) rw = 1'b1;
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm_of(o), ill};
    endfunction

    function automatic logic [17:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, illegal};
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Runs cycles [0, ncyc) of one instruction; ncyc < 0 runs the whole instruction.
    // zmode/lmode: 0 or 1 forces the flag, 2 randomizes it each cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                             input int zmode, input int lmode, input int ncyc);
        int cls = classify(o, f);
        int n = (ncyc < 0) ? latency(cls) : ncyc;
        for (int k = 0; k < n; k++) begin
            op = o; funct3 = f; funct7b5 = f7;
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            lt   = (lmode == 2) ? 1'($urandom) : 1'(lmode);
            @(negedge clk);
            check($sformatf("cyc%0d op=%b f3=%b f7=%b", k, o, f, f7), observed(),
                  model(cls, k, o, f, f7, zero, lt));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
                                 7'b1111111};
        rst = 1'b1; op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
        @(negedge clk);
        check("reset_enables", {26'd0, PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 31'd0);
        check("reset_fetch_sel", {16'd0, ALUSrcB}, 18'b10);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed sequences
        run_instr(7'b0000011, 3'd2, 1'b0, 2, 2, -1);      // lw
        run_instr(7'b0100011, 3'd2, 1'b0, 2, 2, -1);      // sw
        run_instr(7'b1100011, 3'd1, 1'b0, 0, 2, -1);      // bne, not equal
        run_instr(7'b1100011, 3'd1, 1'b0, 1, 2, -1);      // bne, equal
        run_instr(7'b1100011, 3'd5, 1'b0, 2, 1, -1);      // bge, less
        run_instr(7'b0110011, 3'd0, 1'b1, 2, 2, -1);      // sub
        run_instr(7'b0110011, 3'd1, 1'b0, 2, 2, -1);      // sll rejected
        run_instr(7'b1100111, 3'd0, 1'b0, 2, 2, -1);      // jalr
        run_instr(7'b1101111, 3'd3, 1'b1, 2, 2, -1);      // jal
        run_instr(7'b0110111, 3'd0, 1'b0, 2, 2, -1);      // lui
        run_instr(7'b0010111, 3'd0, 1'b0, 2, 2, -1);      // auipc
        run_instr(7'b0000011, 3'd0, 1'b0, 2, 2, -1);      // lb rejected

        // Reset during lw writeback must kill the register write
        run_instr(7'b0000011, 3'd2, 1'b0, 2, 2, 4);
        @(negedge clk);
        check("lw_memwb", observed(), model(C_LW, 4, 7'b0000011, 3'd2, 1'b0, zero, lt));
        #2 rst = 1'b1;
        #1;
        check("rst_abort_enables", {26'd0, PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 31'd0);
        check("rst_abort_fetch", {15'd0, AdrSrc, ALUSrcB}, 18'b010);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_irwrite", {17'd0, IRWrite}, 18'd1);
        run_instr(7'b0010011, 3'd4, 1'b0, 2, 2, -1);      // xori after reset

        // Random instruction stream
        for (int i = 0; i < 250; i++) begin
            int idx = $urandom_range(0, 11);
            logic [6:0] o = (idx == 11) ? 7'($urandom) : ops[idx];
            run_instr(o, 3'($urandom), 1'($urandom), 2, 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
